// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Load/store responder between the EX stage and data memory.
//               Takes MemRead/MemWrite intent, runs a valid/ready request
//               and a response-wait with timeout, stalls the pipeline while
//               busy and returns tagged load data for writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [4:0]        rd_in,
   output logic              stall,
   output logic              load_valid,
   output logic [DATA_W-1:0] load_data,
   output logic [4:0]        load_rd,
   output logic              store_done,
   output logic              misalign_err,
   output logic              bus_err,
   output logic              m_req_valid,
   input  logic              m_req_ready,
   output logic              m_req_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_rsp_valid,
   input  logic [DATA_W-1:0] m_rsp_data
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REQ      = 2'd1,
      S_WAIT_RSP = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [7:0]          r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [4:0]          r_rd;
   logic                r_we;
   logic                r_err;
   logic                r_misalign;
   logic [DATA_W-1:0]   r_load_data;
   logic [4:0]          r_load_rd;

   logic                w_req;
   logic                w_legal;
   logic                w_illegal;
   logic [7:0]          w_cnt_inc;
   logic                w_timeout;

   // A request is legal only if it is exactly one of load/store and word aligned;
   // asserting both strobes is treated the same as a misaligned access.
   assign w_req     = mem_read | mem_write;
   assign w_legal   = w_req & ~(mem_read & mem_write) & (addr[1:0] == 2'b00);
   assign w_illegal = w_req & ~w_legal;
   assign w_cnt_inc = r_cnt + 8'd1;
   assign w_timeout = (w_cnt_inc == C_TIMEOUT);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a response in the timeout cycle takes priority over the error.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_legal) w_state_nxt = S_REQ;
         S_REQ:      if (m_req_ready) w_state_nxt = r_we ? S_DONE : S_WAIT_RSP;
         S_WAIT_RSP: if (m_rsp_valid || w_timeout) w_state_nxt = S_DONE;
         S_DONE:     w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Request latch, wait counter, error flag and writeback registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= 8'd0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rd        <= 5'd0;
         r_we        <= 1'b0;
         r_err       <= 1'b0;
         r_misalign  <= 1'b0;
         r_load_data <= '0;
         r_load_rd   <= 5'd0;
      end else begin
         r_misalign <= (r_state == S_IDLE) & w_illegal;
         case (r_state)
            S_IDLE: begin
               if (w_legal) begin
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_rd    <= rd_in;
                  r_we    <= mem_write;
               end
            end
            S_REQ: begin
               r_err <= 1'b0;
               if (m_req_ready) r_cnt <= 8'd0;
            end
            S_WAIT_RSP: begin
               r_cnt <= w_cnt_inc;
               if (m_rsp_valid) begin
                  r_load_data <= m_rsp_data;
                  r_load_rd   <= r_rd;
               end else if (w_timeout) begin
                  r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign stall        = ((r_state == S_IDLE) & w_legal) | (r_state == S_REQ) |
                         (r_state == S_WAIT_RSP);
   assign m_req_valid  = (r_state == S_REQ);
   assign m_req_we     = r_we;
   assign m_addr       = r_addr;
   assign m_wdata      = r_wdata;
   assign load_valid   = (r_state == S_DONE) & ~r_we & ~r_err;
   assign store_done   = (r_state == S_DONE) & r_we;
   assign bus_err      = (r_state == S_DONE) & r_err;
   assign misalign_err = r_misalign;
   assign load_data    = r_load_data;
   assign load_rd      = r_load_rd;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Self-checking bench for lsu_mem_ctrl. Each operation is
//               expanded into its expected cycle timeline from the memory
//               delays the bench chooses; a compare process checks the DUT
//               against that timeline on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write;
   logic [31:0] addr, wdata;
   logic [4:0]  rd_in;
   logic        stall, load_valid, store_done, misalign_err, bus_err;
   logic [31:0] load_data;
   logic [4:0]  load_rd;
   logic        m_req_valid, m_req_ready, m_req_we, m_rsp_valid;
   logic [31:0] m_addr, m_wdata, m_rsp_data;

   lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata), .rd_in(rd_in),
      .stall(stall), .load_valid(load_valid), .load_data(load_data), .load_rd(load_rd),
      .store_done(store_done), .misalign_err(misalign_err), .bus_err(bus_err),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
      .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // expected values for the current cycle
   logic        check_en = 1'b0;
   logic        exp_stall, exp_mreq, exp_lv, exp_sd, exp_be, exp_mis;
   logic        exp_we;
   logic [31:0] exp_addr, exp_wdata;
   logic        mis_pend = 1'b0;
   logic [31:0] model_data = 32'd0;
   logic [4:0]  model_rd = 5'd0;

   // observation counters used by the literal checks
   int          stall_cnt, lv_cnt, sd_cnt, be_cnt, mis_cnt, hs_cnt;
   logic [31:0] hs_addr [0:7];
   logic        hs_we   [0:7];
   logic [31:0] hs_wdata[0:7];
   logic [31:0] lv_data;
   logic [4:0]  lv_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic clr_cnt();
      stall_cnt = 0; lv_cnt = 0; sd_cnt = 0; be_cnt = 0; mis_cnt = 0; hs_cnt = 0;
   endtask

   // Per-cycle comparison against the expected timeline.
   always @(negedge clk) begin
      if (check_en && rst_n) begin
         chk("stall", 32'(stall), 32'(exp_stall));
         chk("m_req_valid", 32'(m_req_valid), 32'(exp_mreq));
         if (exp_mreq) begin
            chk("m_req_we", 32'(m_req_we), 32'(exp_we));
            chk("m_addr", m_addr, exp_addr);
            chk("m_wdata", m_wdata, exp_wdata);
         end
         chk("load_valid", 32'(load_valid), 32'(exp_lv));
         chk("store_done", 32'(store_done), 32'(exp_sd));
         chk("bus_err", 32'(bus_err), 32'(exp_be));
         chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
         chk("load_data", load_data, model_data);
         chk("load_rd", 32'(load_rd), 32'(model_rd));
         if (stall) stall_cnt++;
         if (store_done) sd_cnt++;
         if (bus_err) be_cnt++;
         if (misalign_err) mis_cnt++;
         if (load_valid) begin
            lv_cnt++;
            lv_data = load_data;
            lv_rd   = load_rd;
         end
         if (m_req_valid && m_req_ready) begin
            if (hs_cnt < 8) begin
               hs_addr[hs_cnt]  = m_addr;
               hs_we[hs_cnt]    = m_req_we;
               hs_wdata[hs_cnt] = m_wdata;
            end
            hs_cnt++;
         end
      end
   end

   // One clock cycle: drive inputs, publish expectations, advance to posedge+1.
   task automatic step(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rdy, input logic rv, input logic [31:0] rdat,
                       input logic e_st, input logic e_mq, input logic e_lv, input logic e_sd,
                       input logic e_be, input logic pend_next);
      mem_read = mr; mem_write = mw; addr = a; wdata = wd; rd_in = rd;
      m_req_ready = rdy; m_rsp_valid = rv; m_rsp_data = rdat;
      exp_stall = e_st; exp_mreq = e_mq; exp_lv = e_lv; exp_sd = e_sd; exp_be = e_be;
      exp_mis = mis_pend;
      mis_pend = pend_next;
      check_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), $urandom,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Busy-cycle stimulus: random request strobes that must be ignored.
   task automatic busy_step(input logic rdy, input logic rv, input logic [31:0] rdat,
                            input logic e_mq);
      step(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), rdy, rv, rdat,
           1'b1, e_mq, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // One instruction: memory accepts after rdy_dly REQ wait cycles, and a load's
   // response arrives in WAIT cycle rsp_dly (none if rsp_dly exceeds the timeout).
   task automatic run_op(input logic rop, input logic wop, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
      logic legal;
      logic ok;
      int   nwait;
      legal = (rop ^ wop) && (a[1:0] == 2'b00);
      if (!legal) begin
         step(rop, wop, a, wd, rd, 1'($urandom), 1'($urandom), $urandom,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rop | wop);
         return;
      end
      exp_we = wop; exp_addr = a; exp_wdata = wd;
      step(rop, wop, a, wd, rd, 1'($urandom), 1'($urandom), $urandom,
           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j <= rdy_dly; j++)
         busy_step(j == rdy_dly, 1'($urandom), $urandom, 1'b1);
      ok = 1'b1;
      if (rop) begin
         nwait = (rsp_dly <= TO) ? rsp_dly : TO;
         ok    = (rsp_dly <= TO);
         for (int k = 1; k <= nwait; k++)
            busy_step(1'($urandom), k == rsp_dly, (k == rsp_dly) ? rdata : $urandom, 1'b0);
         if (ok) begin
            model_data = rdata;
            model_rd   = rd;
         end
      end
      // DONE: the pipeline still presents the same instruction, which must be ignored
      step(rop, wop, a, wd, rd, 1'($urandom), 1'($urandom), $urandom,
           1'b0, 1'b0, rop & ok, wop, rop & ~ok, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0; rd_in = '0;
      m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = '0;
      clr_cnt();
      #2;
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_m_req_valid", 32'(m_req_valid), 32'd0);
      chk("reset_load_valid", 32'(load_valid), 32'd0);
      chk("reset_load_data", load_data, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      idle_step();

      // Store, immediately accepted
      clr_cnt();
      run_op(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 5'd3, 0, 1, 32'd0);
      chk("st_hs_cnt", 32'(hs_cnt), 32'd1);
      chk("st_hs_addr", hs_addr[0], 32'h100);
      chk("st_hs_we", 32'(hs_we[0]), 32'd1);
      chk("st_hs_wdata", hs_wdata[0], 32'hDEADBEEF);
      chk("st_stall_cycles", 32'(stall_cnt), 32'd2);
      chk("st_done_cnt", 32'(sd_cnt), 32'd1);

      // Load, ready low for 3 cycles, response 2 cycles after acceptance
      clr_cnt();
      run_op(1'b1, 1'b0, 32'h104, 32'h0, 5'd5, 3, 2, 32'h12345678);
      chk("ld_lv_cnt", 32'(lv_cnt), 32'd1);
      chk("ld_data", lv_data, 32'h12345678);
      chk("ld_rd", 32'(lv_rd), 32'd5);
      chk("ld_stall_cycles", 32'(stall_cnt), 32'd7);

      // Misaligned load
      clr_cnt();
      run_op(1'b1, 1'b0, 32'h102, 32'h0, 5'd1, 0, 1, 32'd0);
      idle_step();
      chk("mis_cnt", 32'(mis_cnt), 32'd1);
      chk("mis_hs_cnt", 32'(hs_cnt), 32'd0);
      chk("mis_stall", 32'(stall_cnt), 32'd0);

      // Timeout with no response, then response on the last allowed cycle
      clr_cnt();
      run_op(1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 0, TO + 1, 32'hAAAA5555);
      chk("to_be_cnt", 32'(be_cnt), 32'd1);
      chk("to_lv_cnt", 32'(lv_cnt), 32'd0);
      chk("to_stall_cycles", 32'(stall_cnt), 32'd6);
      clr_cnt();
      run_op(1'b1, 1'b0, 32'h44, 32'h0, 5'd8, 0, TO, 32'h0BADF00D);
      chk("edge_be_cnt", 32'(be_cnt), 32'd0);
      chk("edge_lv_cnt", 32'(lv_cnt), 32'd1);
      chk("edge_data", lv_data, 32'h0BADF00D);

      // Back-to-back store then load to the same address
      clr_cnt();
      run_op(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 5'd0, 0, 1, 32'd0);
      run_op(1'b1, 1'b0, 32'h200, 32'h0, 5'd9, 0, 1, 32'hCAFEF00D);
      chk("b2b_hs_cnt", 32'(hs_cnt), 32'd2);
      chk("b2b_first_we", 32'(hs_we[0]), 32'd1);
      chk("b2b_second_we", 32'(hs_we[1]), 32'd0);
      chk("b2b_second_addr", hs_addr[1], 32'h200);

      // Reset while waiting for a load response, then a late response
      clr_cnt();
      exp_we = 1'b0; exp_addr = 32'h300; exp_wdata = 32'h0;
      step(1'b1, 1'b0, 32'h300, 32'h0, 5'd4, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      busy_step(1'b1, 1'b0, 32'h0, 1'b1);
      busy_step(1'b0, 1'b0, 32'h0, 1'b0);
      busy_step(1'b0, 1'b0, 32'h0, 1'b0);
      check_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_m_req_valid", 32'(m_req_valid), 32'd0);
      chk("rst_load_valid", 32'(load_valid), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_load_rd", 32'(load_rd), 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      model_data = 32'd0; model_rd = 5'd0; mis_pend = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h55AA55AA,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h55AA55AA,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_late_lv_cnt", 32'(lv_cnt), 32'd0);

      // Randomized operation stream
      for (int i = 0; i < 120; i++) begin
         int          kind;
         int          nidle;
         logic [31:0] a;
         kind  = $urandom_range(0, 9);
         nidle = $urandom_range(0, 2);
         for (int n = 0; n < nidle; n++) idle_step();
         a = {$urandom} & 32'hFFFF_FFFC;
         case (kind)
            0, 1, 2, 3: run_op(1'b1, 1'b0, a, $urandom, 5'($urandom), $urandom_range(0, 3),
                               $urandom_range(1, TO + 2), $urandom);
            4, 5, 6, 7: run_op(1'b0, 1'b1, a, $urandom, 5'($urandom), $urandom_range(0, 3),
                               1, 32'd0);
            8:          run_op(1'($urandom), 1'b1, a | 32'($urandom_range(1, 3)), $urandom,
                               5'($urandom), 0, 1, 32'd0);
            default:    run_op(1'b1, 1'b1, a, $urandom, 5'($urandom), 0, 1, 32'd0);
         endcase
      end
      idle_step();
      idle_step();
      check_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
